seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_if.sv | 26 ++
 rtl/seq_divider.sv | 133 +++++++++++++
 tb/tb_seq_divider.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Request/response bundle between a divider client and the seq_divider engine.
// The client drives operands and start; the engine returns the result and status pulses.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             div_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             busy;
  logic             div_end;
  logic             div_zero;
  logic             div_ovf;

  modport master (
    output start, div_signed, a, b,
    input  Hi, Lo, busy, div_end, div_zero, div_ovf
  );

  modport slave (
    input  start, div_signed, a, b,
    output Hi, Lo, busy, div_end, div_zero, div_ovf
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock on operand magnitudes,
// with sign fix-up on the way out. Signed or unsigned is chosen per request.
module seq_divider #(
  parameter int WIDTH          = 32,
  parameter bit SIGNED_DEFAULT = 1'b1
) (
  input logic          clk,
  input logic          reset,
  seq_divider_if.slave bus
);
  localparam int               CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  generate
    if (WIDTH < 4 || WIDTH > 64 || SIGNED_DEFAULT > 1'b1) begin : g_bad_param
      $error("seq_divider: WIDTH must be 4..64");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sgn;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_div_end;
  logic             r_div_zero;
  logic             r_div_ovf;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_lo_fix;
  logic [WIDTH-1:0] w_hi_fix;
  logic             w_ovf;

  assign w_a_neg = bus.div_signed & bus.a[WIDTH-1];
  assign w_b_neg = bus.div_signed & bus.b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -bus.a : bus.a;
  assign w_b_mag = w_b_neg ? -bus.b : bus.b;

  // Partial remainder never exceeds the divisor, so the extra top bits only carry the borrow.
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_diff  = w_shift - {2'b00, r_dvs};
  assign w_ge    = ~w_diff[WIDTH+1];

  assign w_lo_fix = r_q_neg ? -r_q : r_q;
  assign w_hi_fix = r_r_neg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
  // MIN / -1: magnitude 2^(W-1) negates back onto itself, so Lo is already MIN.
  assign w_ovf    = r_sgn && (r_a == MIN) && (r_b == {WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_sgn      <= 1'b0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_dvs      <= '0;
      r_q        <= '0;
      r_rem      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_div_end  <= 1'b0;
      r_div_zero <= 1'b0;
      r_div_ovf  <= 1'b0;
    end else begin
      r_div_end  <= 1'b0;
      r_div_zero <= 1'b0;
      r_div_ovf  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (bus.b == '0) begin
              r_div_zero <= 1'b1;
            end else begin
              r_a     <= bus.a;
              r_b     <= bus.b;
              r_sgn   <= bus.div_signed;
              r_q_neg <= w_a_neg ^ w_b_neg;
              r_r_neg <= w_a_neg;
              r_q     <= w_a_mag;
              r_dvs   <= w_b_mag;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_ge ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) r_state <= FINISH;
        end
        FINISH: begin
          r_lo      <= w_lo_fix;
          r_hi      <= w_hi_fix;
          r_div_end <= 1'b1;
          r_div_ovf <= w_ovf;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Hi       = r_hi;
  assign bus.Lo       = r_lo;
  assign bus.busy     = r_busy;
  assign bus.div_end  = r_div_end;
  assign bus.div_zero = r_div_zero;
  assign bus.div_ovf  = r_div_ovf;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed vectors on a 32-bit and an 8-bit instance.
module tb_seq_divider;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_divider_if #(.WIDTH(32)) bus32();
  seq_divider_if #(.WIDTH(8))  bus8();

  seq_divider #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  typedef struct {
    logic        zero;
    logic        ovf;
    logic [31:0] lo;
    logic [31:0] hi;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32;
  exp_t e8;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every div_end/div_zero pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && (bus32.div_end === 1'b1 || bus32.div_zero === 1'b1)) begin
      if (q32.size() == 0) begin
        chk("w32_unexpected_output", 64'(bus32.div_end), 64'(1'b0));
      end else begin
        e32 = q32.pop_front();
        chk("w32_lo",    64'(bus32.Lo), 64'(e32.lo));
        chk("w32_hi",    64'(bus32.Hi), 64'(e32.hi));
        chk("w32_zero",  64'(bus32.div_zero), 64'(e32.zero));
        chk("w32_end",   64'(bus32.div_end), 64'(!e32.zero));
        chk("w32_ovf",   64'(bus32.div_ovf), 64'(e32.ovf));
        chk("w32_busy",  64'(bus32.busy), 64'(1'b0));
        chk("w32_cycle", 64'(cyc), 64'(e32.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0 && (bus8.div_end === 1'b1 || bus8.div_zero === 1'b1)) begin
      if (q8.size() == 0) begin
        chk("w8_unexpected_output", 64'(bus8.div_end), 64'(1'b0));
      end else begin
        e8 = q8.pop_front();
        chk("w8_lo",    64'(bus8.Lo), 64'(e8.lo[7:0]));
        chk("w8_hi",    64'(bus8.Hi), 64'(e8.hi[7:0]));
        chk("w8_zero",  64'(bus8.div_zero), 64'(e8.zero));
        chk("w8_end",   64'(bus8.div_end), 64'(!e8.zero));
        chk("w8_ovf",   64'(bus8.div_ovf), 64'(e8.ovf));
        chk("w8_cycle", 64'(cyc), 64'(e8.cyc));
      end
    end
  end

  // Issue at a negedge; returns at the negedge showing div_end/div_zero so the next
  // request lands in the div_end cycle. Optional noise pokes start/operands mid-calc.
  task automatic do32(input logic sg, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] lo, input logic [31:0] hi, input logic ovf,
                      input bit noise);
    exp_t e;
    int   n;
    e.zero = (b == 32'd0);
    e.ovf  = ovf;
    e.lo   = lo;
    e.hi   = hi;
    e.cyc  = cyc + ((b == 32'd0) ? 1 : 34);
    q32.push_back(e);
    bus32.start      = 1'b1;
    bus32.div_signed = sg;
    bus32.a          = a;
    bus32.b          = b;
    @(negedge clk);
    bus32.start = 1'b0;
    chk("w32_busy_after_start", 64'(bus32.busy), 64'(b != 32'd0));
    n = 0;
    while (!(bus32.div_end === 1'b1 || bus32.div_zero === 1'b1) && n < 100) begin
      if (noise && n == 4) begin
        bus32.start      = 1'b1;
        bus32.a          = $urandom;
        bus32.b          = $urandom;
        bus32.div_signed = ~sg;
      end
      if (noise && n == 12) bus32.start = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("w32_timeout", 64'(n), 64'(0));
  endtask

  task automatic do8(input logic sg, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] lo, input logic [7:0] hi, input logic ovf);
    exp_t e;
    int   n;
    e.zero = (b == 8'd0);
    e.ovf  = ovf;
    e.lo   = {24'd0, lo};
    e.hi   = {24'd0, hi};
    e.cyc  = cyc + ((b == 8'd0) ? 1 : 10);
    q8.push_back(e);
    bus8.start      = 1'b1;
    bus8.div_signed = sg;
    bus8.a          = a;
    bus8.b          = b;
    @(negedge clk);
    bus8.start = 1'b0;
    chk("w8_busy_after_start", 64'(bus8.busy), 64'(b != 8'd0));
    n = 0;
    while (!(bus8.div_end === 1'b1 || bus8.div_zero === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("w8_timeout", 64'(n), 64'(0));
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    bus32.start = 1'b0; bus32.div_signed = 1'b0; bus32.a = '0; bus32.b = '0;
    bus8.start  = 1'b0; bus8.div_signed  = 1'b0; bus8.a  = '0; bus8.b  = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi",       64'(bus32.Hi), 64'(0));
    chk("rst_lo",       64'(bus32.Lo), 64'(0));
    chk("rst_busy",     64'(bus32.busy), 64'(0));
    chk("rst_div_end",  64'(bus32.div_end), 64'(0));
    chk("rst_div_zero", 64'(bus32.div_zero), 64'(0));
    chk("rst_div_ovf",  64'(bus32.div_ovf), 64'(0));
    chk("rst8_lo",      64'(bus8.Lo), 64'(0));
    chk("rst8_busy",    64'(bus8.busy), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    do32(1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b1);
    do32(1'b1, 32'd55,         32'd0,          32'd14,         32'd2,          1'b0, 1'b0);
    do32(1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b1);
    do32(1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0);
    do32(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b1, 1'b0);
    do32(1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 1'b0);
    do32(1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 1'b0);
    do32(1'b1, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0, 1'b0);
    do32(1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1'b0);
    do32(1'b0, 32'd1000,       32'd1,          32'd1000,       32'd0,          1'b0, 1'b1);
    do32(1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0);

    // Abort: reset lands on edge E0+10; nothing may complete afterwards.
    bus32.start = 1'b1; bus32.div_signed = 1'b1; bus32.a = 32'd100; bus32.b = 32'd7;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(bus32.busy), 64'(0));
    chk("abort_hi",   64'(bus32.Hi), 64'(0));
    chk("abort_lo",   64'(bus32.Lo), 64'(0));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus32.div_end === 1'b1) seen++;
    end
    chk("abort_no_div_end", 64'(seen), 64'(0));

    do32(1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0);

    do8(1'b1, 8'hEC, 8'd3,  8'hFA, 8'hFE, 1'b0);
    do8(1'b0, 8'hEC, 8'd3,  8'h4E, 8'h02, 1'b0);
    do8(1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b1);
    do8(1'b1, 8'h11, 8'h00, 8'h80, 8'h00, 1'b0);

    repeat (5) @(negedge clk);
    chk("q32_drained", 64'(q32.size()), 64'(0));
    chk("q8_drained",  64'(q8.size()),  64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
